axi_burst_arb: RTL
==================

# axi_burst_arb

Two-requester burst arbiter sharing the single pcore AXI master port between the hline z-buffer rasterizer (requester 0) and a second burst engine, e.g. the clear/blit unit (requester 1). The arbiter grants the port for one complete burst at a time, using round-robin order. It latches the address and direction at grant and routes `axi_done` back to the owner only. A watchdog releases the port if a burst never completes.

## Interface
- `ADDR_W`, 32, address width
- `TIMEOUT`, 4096, max cycles a grant may be held without `bus_done`; 0 disables the watchdog
- `clk` in 1 — single clock, all state on rising edge
- `nreset` in 1 — asynchronous, active-low reset
- `m0_rd_req`, `m0_wr_req` in 1 each — requester 0 burst read/write request, level, held until its done
- `m0_addr` in ADDR_W — requester 0 burst address
- `m0_done` out 1 — burst-complete pulse to requester 0
- `m1_rd_req`, `m1_wr_req`, `m1_addr`, `m1_done` — same for requester 1
- `bus_rd_req`, `bus_wr_req` out 1 — to AXI master
- `bus_addr` out ADDR_W — to AXI master
- `bus_done` in 1 — AXI burst completion pulse
- `grant` out 2 — one-hot current owner; used as FIFO data-route select
- `busy` out 1 — a burst is in flight
- `timeout_err` out 1 — sticky watchdog flag
- `err_clr` in 1 — clears `timeout_err`

## Operation
- States: IDLE, BUSY, GAP.
- **IDLE:** a requester is active if its `rd_req` or `wr_req` is high. If neither is active, stay. If exactly one is active, grant it. If both are active, grant the one that is not `last_owner`. On grant:
  - latch owner, address and direction (read when `rd_req`, else write);
  - update `last_owner`;
  - go to BUSY.
- Requester asserting both `rd_req` and `wr_req`: take the read and set `timeout_err` (protocol error).
- **BUSY:**
  - `bus_rd_req` or `bus_wr_req` is high per the latched direction; `bus_addr` is the latched address.
  - `bus_done` is passed combinationally to the owner's `mX_done`; the non-owner's done stays 0.
  - On `bus_done`, go to GAP.
- **GAP:** one cycle, all bus requests low. This lets the owner's FSM drop or change its request, so a stale level is not re-granted.
- **Watchdog:** a counter clears on entering BUSY and increments each BUSY cycle. If it reaches `TIMEOUT-1` with no `bus_done`:
  - pulse the owner's done for one cycle;
  - set `timeout_err`;
  - go to GAP.
- `err_clr` clears `timeout_err`. A simultaneous set wins over the clear.
- Requests dropping while in BUSY are ignored; the burst is owned until done or timeout.
- Address or direction changes during BUSY are ignored; the latched values are used.

## Timing
- Reset values: state IDLE, `grant`=00, `busy`=0, all bus requests 0, `bus_addr`=0, `m0_done`/`m1_done`=0, `timeout_err`=0, `last_owner`=1 (so requester 0 wins the first tie), watchdog=0.
- Reset is asynchronous. Asserting it mid-burst drops bus requests immediately, with no done pulse to any requester.
- Grant latency: request high in IDLE at cycle N gives BUSY with bus request high at N+1.
- `bus_done` at cycle K gives `mX_done` at K, GAP at K+1, IDLE at K+2, and the next earliest grant at K+3.
- `grant`, `busy`, bus requests and `bus_addr` are registered; only `mX_done` is combinational from `bus_done`.
- `bus_done` in IDLE or GAP is ignored.

## Structure
- Shared package `gpu_arb_pkg`: state localparams (IDLE=0, BUSY=1, GAP=2), direction constants `DIR_RD`/`DIR_WR`, and a grant one-hot helper.
- One sub-module, `burst_watchdog`: parameter `TIMEOUT`; inputs `clear` and `run`; output `expired`. With `TIMEOUT`=0, `expired` is tied to 0.

## Test plan
- **Single read:** `m0_rd_req`=1, `m0_addr`=0x1000_0000, `bus_done` 20 cycles later.
  - Expect `bus_rd_req` and `grant`=01 one cycle after the request, `bus_addr`=0x1000_0000, and `m0_done` in the same cycle as `bus_done`.
  - Expect `m1_done`=0 throughout.
- **Simultaneous requests after reset:** `m0_wr_req` and `m1_rd_req` both held.
  - Expect grant order m0, m1, m0, m1 across four bursts, with a one-cycle GAP (all requests 0) between bursts.
- **Stale request:** m0 holds `rd_req` one cycle past its `m0_done`, then drops it.
  - Expect no second grant to m0; `bus_rd_req`=0 during GAP.
- **Watchdog:** `TIMEOUT`=16, grant m1, never assert `bus_done`.
  - Expect `m1_done` pulse at BUSY cycle 16, `timeout_err`=1 and sticky, then the port freed for m0.
  - `err_clr` clears the flag.
- **Async reset mid-burst:** assert `nreset`=0 in BUSY.
  - Expect `bus_wr_req`=0 and `grant`=00 before the next clock edge.
  - After release, m0 wins the first tie.
- **Both directions from one requester:** m1 asserts `rd_req` and `wr_req` together.
  - Expect `bus_rd_req`=1, `bus_wr_req`=0, `timeout_err`=1.

Source files
------------

// File: rtl/gpu_arb_pkg.sv
//------------------------------------------------------------------------------
// Module   : gpu_arb_pkg
// Purpose  : Shared state encoding, direction constants and grant helper for
//            the pcore AXI burst arbiter.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package gpu_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2
    } arb_state_t;

    localparam logic DIR_RD = 1'b0;
    localparam logic DIR_WR = 1'b1;

    function automatic logic [1:0] grant_onehot(input logic owner);
        return owner ? 2'b10 : 2'b01;
    endfunction

endpackage

`default_nettype wire

// File: rtl/burst_watchdog.sv
//------------------------------------------------------------------------------
// Module   : burst_watchdog
// Purpose  : Cycle counter that flags a burst held for TIMEOUT cycles.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module burst_watchdog #(
    parameter int TIMEOUT = 4096
) (
    input  logic clk,
    input  logic nreset,
    input  logic clear,
    input  logic run,
    output logic expired
);

    generate
        if (TIMEOUT == 0) begin : g_disabled
            logic w_unused;
            assign w_unused = ^{clk, nreset, clear, run};
            assign expired  = 1'b0;
        end else begin : g_enabled
            localparam int              CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
            localparam logic [CNT_W-1:0] c_last = CNT_W'(TIMEOUT - 1);

            logic [CNT_W-1:0] r_count;

            // Saturates at the terminal count so expiry cannot wrap around.
            always_ff @(posedge clk or negedge nreset) begin
                if (!nreset) begin
                    r_count <= '0;
                end else if (clear) begin
                    r_count <= '0;
                end else if (run && (r_count != c_last)) begin
                    r_count <= r_count + 1'b1;
                end
            end

            assign expired = run && (r_count == c_last);
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/axi_burst_arb.sv
//------------------------------------------------------------------------------
// Module   : axi_burst_arb
// Purpose  : Round-robin, whole-burst arbiter sharing one AXI master port
//            between two burst engines, with a hung-burst watchdog.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module axi_burst_arb
    import gpu_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 4096
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              m0_rd_req,
    input  logic              m0_wr_req,
    input  logic [ADDR_W-1:0] m0_addr,
    output logic              m0_done,
    input  logic              m1_rd_req,
    input  logic              m1_wr_req,
    input  logic [ADDR_W-1:0] m1_addr,
    output logic              m1_done,
    output logic              bus_rd_req,
    output logic              bus_wr_req,
    output logic [ADDR_W-1:0] bus_addr,
    input  logic              bus_done,
    output logic [1:0]        grant,
    output logic              busy,
    output logic              timeout_err,
    input  logic              err_clr
);

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    logic              r_owner;
    logic              r_last_owner;
    logic [ADDR_W-1:0] r_addr;
    logic [1:0]        r_grant;
    logic              r_busy;
    logic              r_bus_rd;
    logic              r_bus_wr;
    logic              r_timeout_err;

    logic              w_act0;
    logic              w_act1;
    logic              w_grant_en;
    logic              w_sel;
    logic              w_sel_rd;
    logic              w_sel_wr;
    logic              w_dir;
    logic [ADDR_W-1:0] w_sel_addr;
    logic              w_release;
    logic              w_expire_err;
    logic              w_proto_err;
    logic              w_expired;
    logic              w_done;

    assign w_act0 = m0_rd_req | m0_wr_req;
    assign w_act1 = m1_rd_req | m1_wr_req;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_grant_en   = 1'b0;
        w_sel        = 1'b0;
        w_release    = 1'b0;
        w_expire_err = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_act0 || w_act1) begin
                    w_grant_en  = 1'b1;
                    // On a tie the requester that did not own the last burst wins.
                    w_sel       = (w_act0 && w_act1) ? ~r_last_owner : w_act1;
                    w_state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (bus_done) begin
                    w_release   = 1'b1;
                    w_state_nxt = GAP;
                end else if (w_expired) begin
                    w_release    = 1'b1;
                    w_expire_err = 1'b1;
                    w_state_nxt  = GAP;
                end
            end
            GAP: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign w_sel_rd    = w_sel ? m1_rd_req : m0_rd_req;
    assign w_sel_wr    = w_sel ? m1_wr_req : m0_wr_req;
    assign w_sel_addr  = w_sel ? m1_addr   : m0_addr;
    assign w_dir       = w_sel_rd ? DIR_RD : DIR_WR;
    assign w_proto_err = w_grant_en && w_sel_rd && w_sel_wr;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_owner      <= 1'b0;
            r_last_owner <= 1'b1;
            r_addr       <= '0;
            r_grant      <= 2'b00;
            r_busy       <= 1'b0;
            r_bus_rd     <= 1'b0;
            r_bus_wr     <= 1'b0;
        end else if (w_grant_en) begin
            r_owner      <= w_sel;
            r_last_owner <= w_sel;
            r_addr       <= w_sel_addr;
            r_grant      <= grant_onehot(w_sel);
            r_busy       <= 1'b1;
            r_bus_rd     <= (w_dir == DIR_RD);
            r_bus_wr     <= (w_dir == DIR_WR);
        end else if (w_release) begin
            r_grant      <= 2'b00;
            r_busy       <= 1'b0;
            r_bus_rd     <= 1'b0;
            r_bus_wr     <= 1'b0;
        end
    end

    // A new error in the same cycle as err_clr keeps the flag set.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_timeout_err <= 1'b0;
        end else if (w_expire_err || w_proto_err) begin
            r_timeout_err <= 1'b1;
        end else if (err_clr) begin
            r_timeout_err <= 1'b0;
        end
    end

    burst_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .nreset  (nreset),
        .clear   (w_grant_en),
        .run     (r_state == BUSY),
        .expired (w_expired)
    );

    assign w_done      = (r_state == BUSY) && (bus_done || w_expired);
    assign m0_done     = w_done && !r_owner;
    assign m1_done     = w_done &&  r_owner;

    assign bus_rd_req  = r_bus_rd;
    assign bus_wr_req  = r_bus_wr;
    assign bus_addr    = r_addr;
    assign grant       = r_grant;
    assign busy        = r_busy;
    assign timeout_err = r_timeout_err;

endmodule

`default_nettype wire
